// File: rtl/mem_stage_if.sv
// Execute / data-memory / writeback signal bundle for mem_stage.
// slave = the stage itself; master = whatever drives execute, memory and writeback.
interface mem_stage_if;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_inst;
   logic [31:0] i_pc;
   logic [31:0] i_next_pc;
   logic [31:0] i_alu;
   logic [31:0] i_store_data;
   logic [2:0]  i_funct3;
   logic        i_mem_read;
   logic        i_mem_write;
   logic        i_reg_write;
   logic        i_mem_to_reg;
   logic [4:0]  i_rd_waddr;
   logic        i_trap;

   logic        o_dmem_req;
   logic        i_dmem_ready;
   logic [31:0] o_dmem_addr;
   logic        o_dmem_wen;
   logic [31:0] o_dmem_wdata;
   logic [3:0]  o_dmem_mask;
   logic        i_dmem_valid;
   logic [31:0] i_dmem_rdata;

   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic [31:0] o_next_pc;
   logic [31:0] o_alu;
   logic [31:0] o_load_data;
   logic [4:0]  o_rd_waddr;
   logic        o_reg_write;
   logic        o_mem_to_reg;
   logic        o_trap;

   modport slave (
      input  i_valid, i_inst, i_pc, i_next_pc, i_alu, i_store_data, i_funct3,
             i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_rd_waddr, i_trap,
             i_dmem_ready, i_dmem_valid, i_dmem_rdata,
      output o_ready, o_dmem_req, o_dmem_addr, o_dmem_wen, o_dmem_wdata, o_dmem_mask,
             o_valid, o_inst, o_pc, o_next_pc, o_alu, o_load_data, o_rd_waddr,
             o_reg_write, o_mem_to_reg, o_trap
   );

   modport master (
      output i_valid, i_inst, i_pc, i_next_pc, i_alu, i_store_data, i_funct3,
             i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_rd_waddr, i_trap,
             i_dmem_ready, i_dmem_valid, i_dmem_rdata,
      input  o_ready, o_dmem_req, o_dmem_addr, o_dmem_wen, o_dmem_wdata, o_dmem_mask,
             o_valid, o_inst, o_pc, o_next_pc, o_alu, o_load_data, o_rd_waddr,
             o_reg_write, o_mem_to_reg, o_trap
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: lane alignment, masks, load extension, M/W register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module mem_stage (
   input  logic       i_clk,
   input  logic       i_rst,
   mem_stage_if.slave bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned LANES = 4;
   localparam int unsigned RDW   = 5;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state_q, state_d;
   logic              ready_q, ready_d;
   logic              req_q, req_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [LANES-1:0]  mask_q, mask_d;

   // instruction context held while the memory transaction is in flight
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   l_inst_q, l_inst_d;
   logic [XLEN-1:0]   l_pc_q, l_pc_d;
   logic [XLEN-1:0]   l_npc_q, l_npc_d;
   logic [XLEN-1:0]   l_alu_q, l_alu_d;
   logic [RDW-1:0]    l_rd_q, l_rd_d;
   logic              l_rw_q, l_rw_d;
   logic              l_m2r_q, l_m2r_d;

   logic              mw_valid_q, mw_valid_d;
   logic [XLEN-1:0]   mw_inst_q, mw_inst_d;
   logic [XLEN-1:0]   mw_pc_q, mw_pc_d;
   logic [XLEN-1:0]   mw_npc_q, mw_npc_d;
   logic [XLEN-1:0]   mw_alu_q, mw_alu_d;
   logic [XLEN-1:0]   mw_ld_q, mw_ld_d;
   logic [RDW-1:0]    mw_rd_q, mw_rd_d;
   logic              mw_rw_q, mw_rw_d;
   logic              mw_m2r_q, mw_m2r_d;
   logic              mw_trap_q, mw_trap_d;

   logic              accept;
   logic              is_mem;
   logic              trap_c;
   logic [1:0]        off_c;
   logic              finish;
   logic [XLEN-1:0]   finish_ld;

   function automatic logic [LANES-1:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   lane_mask = 4'(4'b0001 << off);
         2'b01:   lane_mask = 4'(4'b0011 << off);
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] off,
                                                   input logic [2:0] f3);
      logic [XLEN-1:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3[1:0])
         2'b00:   extend_load = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   extend_load = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: extend_load = sh;
      endcase
   endfunction

   assign accept = bus.i_valid & ready_q;
   assign is_mem = bus.i_mem_read | bus.i_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misalign;
   always_comb begin
      case (bus.i_funct3[1:0])
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = bus.i_alu[0];
         default: misalign = |bus.i_alu[1:0];
      endcase
   end
   assign trap_c = bus.i_trap | (is_mem & misalign);
   assign off_c  = bus.i_alu[1:0];
`else
   assign trap_c = bus.i_trap;
   always_comb begin
      case (bus.i_funct3[1:0])
         2'b00:   off_c = bus.i_alu[1:0];
         2'b01:   off_c = {bus.i_alu[1], 1'b0};
         default: off_c = 2'b00;
      endcase
   end
`endif

   // next-state and datapath
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      addr_d     = addr_q;
      wen_d      = wen_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;
      off_d      = off_q;
      f3_d       = f3_q;
      l_inst_d   = l_inst_q;
      l_pc_d     = l_pc_q;
      l_npc_d    = l_npc_q;
      l_alu_d    = l_alu_q;
      l_rd_d     = l_rd_q;
      l_rw_d     = l_rw_q;
      l_m2r_d    = l_m2r_q;
      mw_valid_d = 1'b0;
      mw_inst_d  = mw_inst_q;
      mw_pc_d    = mw_pc_q;
      mw_npc_d   = mw_npc_q;
      mw_alu_d   = mw_alu_q;
      mw_ld_d    = mw_ld_q;
      mw_rd_d    = mw_rd_q;
      mw_rw_d    = mw_rw_q;
      mw_m2r_d   = mw_m2r_q;
      mw_trap_d  = mw_trap_q;
      finish     = 1'b0;
      finish_ld  = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_mem && !trap_c) begin
                  state_d  = REQ;
                  req_d    = 1'b1;
                  addr_d   = {bus.i_alu[XLEN-1:2], 2'b00};
                  wen_d    = bus.i_mem_write;
                  wdata_d  = bus.i_store_data << {off_c, 3'b000};
                  mask_d   = lane_mask(bus.i_funct3, off_c);
                  off_d    = off_c;
                  f3_d     = bus.i_funct3;
                  l_inst_d = bus.i_inst;
                  l_pc_d   = bus.i_pc;
                  l_npc_d  = bus.i_next_pc;
                  l_alu_d  = bus.i_alu;
                  l_rd_d   = bus.i_rd_waddr;
                  l_rw_d   = bus.i_reg_write;
                  l_m2r_d  = bus.i_mem_to_reg;
               end else begin
                  mw_valid_d = 1'b1;
                  mw_inst_d  = bus.i_inst;
                  mw_pc_d    = bus.i_pc;
                  mw_npc_d   = bus.i_next_pc;
                  mw_alu_d   = bus.i_alu;
                  mw_ld_d    = '0;
                  mw_rd_d    = bus.i_rd_waddr;
                  mw_rw_d    = bus.i_reg_write & ~trap_c;
                  mw_m2r_d   = bus.i_mem_to_reg;
                  mw_trap_d  = trap_c;
               end
            end
         end
         REQ: begin
            if (bus.i_dmem_ready) begin
               req_d = 1'b0;
               if (wen_q) begin
                  state_d = IDLE;
                  finish  = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (bus.i_dmem_valid) begin
               state_d   = IDLE;
               finish    = 1'b1;
               finish_ld = extend_load(bus.i_dmem_rdata, off_q, f3_q);
            end
         end
         default: state_d = IDLE;
      endcase

      // retire a memory instruction from its latched context
      if (finish) begin
         mw_valid_d = 1'b1;
         mw_inst_d  = l_inst_q;
         mw_pc_d    = l_pc_q;
         mw_npc_d   = l_npc_q;
         mw_alu_d   = l_alu_q;
         mw_ld_d    = finish_ld;
         mw_rd_d    = l_rd_q;
         mw_rw_d    = l_rw_q;
         mw_m2r_d   = l_m2r_q;
         mw_trap_d  = 1'b0;
      end

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         req_q      <= 1'b0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         mask_q     <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         l_inst_q   <= '0;
         l_pc_q     <= '0;
         l_npc_q    <= '0;
         l_alu_q    <= '0;
         l_rd_q     <= '0;
         l_rw_q     <= 1'b0;
         l_m2r_q    <= 1'b0;
         mw_valid_q <= 1'b0;
         mw_inst_q  <= '0;
         mw_pc_q    <= '0;
         mw_npc_q   <= '0;
         mw_alu_q   <= '0;
         mw_ld_q    <= '0;
         mw_rd_q    <= '0;
         mw_rw_q    <= 1'b0;
         mw_m2r_q   <= 1'b0;
         mw_trap_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         wen_q      <= wen_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         l_inst_q   <= l_inst_d;
         l_pc_q     <= l_pc_d;
         l_npc_q    <= l_npc_d;
         l_alu_q    <= l_alu_d;
         l_rd_q     <= l_rd_d;
         l_rw_q     <= l_rw_d;
         l_m2r_q    <= l_m2r_d;
         mw_valid_q <= mw_valid_d;
         mw_inst_q  <= mw_inst_d;
         mw_pc_q    <= mw_pc_d;
         mw_npc_q   <= mw_npc_d;
         mw_alu_q   <= mw_alu_d;
         mw_ld_q    <= mw_ld_d;
         mw_rd_q    <= mw_rd_d;
         mw_rw_q    <= mw_rw_d;
         mw_m2r_q   <= mw_m2r_d;
         mw_trap_q  <= mw_trap_d;
      end
   end

   assign bus.o_ready      = ready_q;
   assign bus.o_dmem_req   = req_q;
   assign bus.o_dmem_addr  = addr_q;
   assign bus.o_dmem_wen   = wen_q;
   assign bus.o_dmem_wdata = wdata_q;
   assign bus.o_dmem_mask  = mask_q;
   assign bus.o_valid      = mw_valid_q;
   assign bus.o_inst       = mw_inst_q;
   assign bus.o_pc         = mw_pc_q;
   assign bus.o_next_pc    = mw_npc_q;
   assign bus.o_alu        = mw_alu_q;
   assign bus.o_load_data  = mw_ld_q;
   assign bus.o_rd_waddr   = mw_rd_q;
   assign bus.o_reg_write  = mw_rw_q;
   assign bus.o_mem_to_reg = mw_m2r_q;
   assign bus.o_trap       = mw_trap_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instructions, memory responder and M/W monitor.
module tb_mem_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   bit   mem_en = 1'b0;

   mem_stage_if bus ();
   mem_stage dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] inst, pc, npc, alu, sdata, rdata;
      logic [2:0]  f3;
      logic        rd_en, wr_en, rw, m2r, trap;
      logic [4:0]  rd;
   } ins_t;

   typedef struct {
      logic [31:0] inst, pc, npc, alu, ld;
      logic [4:0]  rd;
      logic        rw, m2r, trap, is_load;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] addr, wdata, rdata;
      logic        wen;
      logic [3:0]  mask;
      int          rdly, vdly;
   } mem_t;

   exp_t exp_q[$];
   mem_t mem_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // reference: byte-level view of an access of 1, 2 or 4 bytes
   function automatic void model(input ins_t x, output logic trap, output logic [31:0] addr,
                                 output logic [3:0] mask, output logic [31:0] wdata,
                                 output logic [31:0] ld);
      int unsigned size, a, off;
      longint unsigned lim, v;
      size = (x.f3[1:0] == 2'b00) ? 1 : (x.f3[1:0] == 2'b01) ? 2 : 4;
      a    = x.alu % 4;
      off  = a - (a % size);
      trap = x.trap;
`ifdef MEM_MISALIGN_TRAP_EN
      if ((x.rd_en || x.wr_en) && (a % size) != 0) trap = 1'b1;
`endif
      addr  = x.alu - a;
      mask  = 4'(((1 << size) - 1) << off);
      wdata = x.sdata << (8 * off);
      lim   = 64'd1 << (8 * size);
      v     = (64'(x.rdata) >> (8 * off)) % lim;
      if (!x.f3[2] && size < 4 && v >= lim / 2) v = v + (64'd1 << 32) - lim;
      ld = 32'(v);
   endfunction

   function automatic ins_t mk(input logic [31:0] alu, sdata, input logic [2:0] f3,
                               input logic rd_en, wr_en, input logic [4:0] rd, input logic trap);
      ins_t x;
      x.inst = $urandom; x.pc = $urandom; x.npc = x.pc + 32'd4;
      x.alu = alu; x.sdata = sdata; x.f3 = f3; x.rdata = $urandom;
      x.rd_en = rd_en; x.wr_en = wr_en; x.rw = !wr_en; x.m2r = rd_en;
      x.rd = rd; x.trap = trap;
      return x;
   endfunction

   task automatic issue(input ins_t x, input int rdly, input int vdly);
      exp_t e;
      mem_t m;
      logic trap, is_mem;
      int   t = 0;
      @(negedge clk);
      while (!bus.o_ready) begin
         @(negedge clk);
         t++;
         if (t > 300) begin fail_now("ready_timeout"); return; end
      end
      bus.i_valid = 1'b1; bus.i_inst = x.inst; bus.i_pc = x.pc; bus.i_next_pc = x.npc;
      bus.i_alu = x.alu; bus.i_store_data = x.sdata; bus.i_funct3 = x.f3;
      bus.i_mem_read = x.rd_en; bus.i_mem_write = x.wr_en; bus.i_reg_write = x.rw;
      bus.i_mem_to_reg = x.m2r; bus.i_rd_waddr = x.rd; bus.i_trap = x.trap;
      model(x, trap, m.addr, m.mask, m.wdata, e.ld);
      is_mem   = (x.rd_en || x.wr_en) && !trap;
      m.wen    = x.wr_en; m.rdata = x.rdata; m.rdly = rdly; m.vdly = vdly;
      e.inst = x.inst; e.pc = x.pc; e.npc = x.npc; e.alu = x.alu; e.rd = x.rd;
      e.rw = x.rw && !trap; e.m2r = x.m2r; e.trap = trap;
      e.is_load = is_mem && !x.wr_en;
      e.cyc = !is_mem ? cyc + 1 : x.wr_en ? cyc + 2 + rdly : cyc + 3 + rdly + vdly;
      if (is_mem) mem_q.push_back(m);
      exp_q.push_back(e);
      @(posedge clk);
      #1 bus.i_valid = 1'b0;
   endtask

   task automatic check_req(input mem_t m, input string tag);
      check({tag, "_req"},   32'(bus.o_dmem_req), 32'd1);
      check({tag, "_addr"},  bus.o_dmem_addr, m.addr);
      check({tag, "_wen"},   32'(bus.o_dmem_wen), 32'(m.wen));
      check({tag, "_wdata"}, m.wen ? bus.o_dmem_wdata : 32'd0, m.wen ? m.wdata : 32'd0);
      check({tag, "_mask"},  32'(bus.o_dmem_mask), 32'(m.mask));
   endtask

   // memory responder: checks each request and answers with the scheduled delays
   initial forever begin
      mem_t m;
      @(negedge clk);
      if (mem_en && bus.o_dmem_req) begin
         if (mem_q.size() == 0) fail_now("unexpected_dmem_req");
         else begin
            m = mem_q.pop_front();
            check_req(m, "dmem");
            repeat (m.rdly) begin
               @(negedge clk);
               check_req(m, "stall");
               check("stall_ready", 32'(bus.o_ready), 32'd0);
            end
            bus.i_dmem_ready = 1'b1;
            @(posedge clk);
            #1 bus.i_dmem_ready = 1'b0;
            if (!m.wen) begin
               @(negedge clk);
               repeat (m.vdly) begin
                  check("resp_ready", 32'(bus.o_ready), 32'd0);
                  @(negedge clk);
               end
               bus.i_dmem_valid = 1'b1;
               bus.i_dmem_rdata = m.rdata;
               @(posedge clk);
               #1 bus.i_dmem_valid = 1'b0;
               bus.i_dmem_rdata = $urandom;
            end
         end
      end
   end

   // M/W monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (mon_en && bus.o_valid) begin
         if (exp_q.size() == 0) fail_now("unexpected_o_valid");
         else begin
            e = exp_q.pop_front();
            check("latency",    32'(cyc), 32'(e.cyc));
            check("o_inst",     bus.o_inst, e.inst);
            check("o_pc",       bus.o_pc, e.pc);
            check("o_next_pc",  bus.o_next_pc, e.npc);
            check("o_alu",      bus.o_alu, e.alu);
            check("o_rd_waddr", 32'(bus.o_rd_waddr), 32'(e.rd));
            check("o_reg_write", 32'(bus.o_reg_write), 32'(e.rw));
            check("o_mem_to_reg", 32'(bus.o_mem_to_reg), 32'(e.m2r));
            check("o_trap",     32'(bus.o_trap), 32'(e.trap));
            if (e.is_load) check("o_load_data", bus.o_load_data, e.ld);
         end
      end
   end

   initial begin
      int f3s[5] = '{0, 1, 2, 4, 5};
      ins_t x;
      int   t;
      bus.i_valid = 0; bus.i_inst = 0; bus.i_pc = 0; bus.i_next_pc = 0; bus.i_alu = 0;
      bus.i_store_data = 0; bus.i_funct3 = 0; bus.i_mem_read = 0; bus.i_mem_write = 0;
      bus.i_reg_write = 0; bus.i_mem_to_reg = 0; bus.i_rd_waddr = 0; bus.i_trap = 0;
      bus.i_dmem_ready = 0; bus.i_dmem_valid = 0; bus.i_dmem_rdata = 0;

      repeat (3) @(negedge clk);
      check("rst_o_ready",    32'(bus.o_ready), 32'd1);
      check("rst_o_valid",    32'(bus.o_valid), 32'd0);
      check("rst_dmem_req",   32'(bus.o_dmem_req), 32'd0);
      check("rst_dmem_wen",   32'(bus.o_dmem_wen), 32'd0);
      check("rst_dmem_mask",  32'(bus.o_dmem_mask), 32'd0);
      check("rst_o_alu",      bus.o_alu, 32'd0);
      check("rst_o_rd_waddr", 32'(bus.o_rd_waddr), 32'd0);
      check("rst_o_reg_write", 32'(bus.o_reg_write), 32'd0);
      rst = 1'b0;

      // reset while waiting for a load response, then a stale response
      @(negedge clk);
      bus.i_valid = 1; bus.i_mem_read = 1; bus.i_alu = 32'h3000; bus.i_funct3 = 3'b010;
      bus.i_reg_write = 1; bus.i_rd_waddr = 5'd7;
      @(negedge clk);
      bus.i_valid = 0;
      check("abort_req", 32'(bus.o_dmem_req), 32'd1);
      bus.i_dmem_ready = 1;
      @(negedge clk);
      bus.i_dmem_ready = 0;
      check("abort_resp_ready", 32'(bus.o_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("abort_rst_ready", 32'(bus.o_ready), 32'd1);
      check("abort_rst_valid", 32'(bus.o_valid), 32'd0);
      check("abort_rst_req",   32'(bus.o_dmem_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.i_mem_read = 0; bus.i_reg_write = 0;
      bus.i_dmem_valid = 1; bus.i_dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.i_dmem_valid = 0;
      check("late_rvalid_valid", 32'(bus.o_valid), 32'd0);
      check("late_rvalid_ready", 32'(bus.o_ready), 32'd1);
      check("late_rvalid_req",   32'(bus.o_dmem_req), 32'd0);

      mon_en = 1'b1;
      mem_en = 1'b1;

      issue(mk(32'h1234, 32'h0, 3'b000, 0, 0, 5'd5, 0), 0, 0);             // add
      issue(mk(32'h2003, 32'hAB, 3'b000, 0, 1, 5'd0, 0), 0, 0);             // sb
      x = mk(32'h1002, 0, 3'b001, 1, 0, 5'd9, 0); x.rdata = 32'h8001_5A5A;
      issue(x, 0, 2);                                                        // lh
      x = mk(32'h1002, 0, 3'b101, 1, 0, 5'd9, 0); x.rdata = 32'h8001_5A5A;
      issue(x, 0, 0);                                                        // lhu
      issue(mk(32'h0040, 32'h1357_9BDF, 3'b010, 0, 1, 5'd0, 0), 4, 0);     // sw, stalled
      x = mk(32'h1001, 0, 3'b010, 1, 0, 5'd3, 0); x.rdata = 32'hCAFE_F00D;
      issue(x, 0, 0);                                                        // lw misaligned
      issue(mk(32'h5006, 32'h55AA, 3'b001, 0, 1, 5'd0, 0), 1, 0);          // sh
      issue(mk(32'h7777, 0, 3'b000, 1, 0, 5'd12, 1), 0, 0);                // upstream trap

      for (int i = 0; i < 300; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         x = mk($urandom, $urandom, 3'(f3s[$urandom_range(0, 4)]),
                kind == 1, kind == 2, 5'($urandom), $urandom_range(0, 7) == 0);
         issue(x, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      t = 0;
      while ((exp_q.size() != 0 || mem_q.size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check("drain_exp_q", 32'(exp_q.size()), 32'd0);
      check("drain_mem_q", 32'(mem_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the hart, between execute and writeback. Takes one instruction at a time from execute and drives a request/response data-memory port. Performs load/store byte-lane alignment, mask generation and load extension. Registers the result into the M/W pipeline register that writeback consumes.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  execute presents an instruction
- o_ready  out  1  stage can accept; high only in IDLE
- i_inst, i_pc, i_next_pc  in  32 each  passed through to writeback
- i_alu  in  32  ALU result; effective address for loads/stores
- i_store_data  in  32  rs2 value for stores
- i_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg  in  1 each  control
- i_rd_waddr  in  5  destination register
- i_trap  in  1  trap already raised upstream
- o_dmem_req  out  1  request valid
- i_dmem_ready  in  1  memory accepts request this cycle
- o_dmem_addr  out  32  word-aligned address, i_alu & ~3
- o_dmem_wen  out  1  1 = write, 0 = read
- o_dmem_wdata  out  32  store data shifted into lanes
- o_dmem_mask  out  4  byte-lane enables
- i_dmem_valid  in  1  read response valid
- i_dmem_rdata  in  32  read response word
- o_valid  out  1  M/W register holds an instruction
- o_inst, o_pc, o_next_pc, o_alu  out  32 each  registered pass-through
- o_load_data  out  32  extended load result
- o_rd_waddr  out  5; o_reg_write, o_mem_to_reg, o_trap  out  1 each

## Operation
- States: IDLE, REQ, RESP.
- IDLE, accept (i_valid & o_ready), with no memory op or with trap set (i_trap or misalignment):
  - Load M/W register next edge, o_valid=1.
  - A trapped instruction forces o_reg_write=0 and issues no request.
- IDLE, accept, with a legal memory op:
  - Latch all inputs, go to REQ. o_valid=0 next cycle.
- REQ:
  - Hold o_dmem_req=1 with stable addr/wen/wdata/mask until i_dmem_ready.
  - Store accepted: load M/W next edge, go to IDLE.
  - Load accepted: go to RESP.
- RESP:
  - Wait for i_dmem_valid, then capture and extend rdata into M/W, go to IDLE.
  - i_dmem_valid arriving in any other state is ignored.
- Mask and lane shift use offset o = i_alu[1:0]:
  - Byte: mask = 1<<o, wdata = data<<(8o).
  - Half: mask = 3<<o.
  - Word: mask = 1111.
- Load data: rdata>>(8o), then sign- or zero-extend from bit 7 or 15 per funct3.
- o_valid is a one-cycle pulse per instruction. Writeback always consumes it.

## Timing
- Reset values: state=IDLE, o_ready=1, o_dmem_req=0, o_dmem_wen=0, o_dmem_mask=0.
- Reset values: o_valid=0, all M/W data/control outputs 0.
- Reset mid-transaction abandons the request with no retry.
- Non-memory op latency: 1 cycle (accept edge → o_valid).
- Store latency: accept → REQ → o_valid the cycle after ready; minimum 2 cycles.
- Load latency: minimum 3 cycles (ready on first REQ cycle, valid on first RESP cycle).
- o_ready is 0 from the cycle after a memory accept until return to IDLE. Execute stalls.
- Memory outputs are registered-state driven only; no combinational path from i_valid.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Halfword at odd offset, or word at offset≠0, sets o_trap=1.
  - No request is issued; the instruction completes in 1 cycle.
- Not defined:
  - Offset is force-aligned (half: o&2, word: 0). No trap is raised.

## Test plan
- Pass-through: add, i_alu=0x1234, rd=5 → one cycle later o_valid=1, o_alu=0x1234, o_rd_waddr=5, no o_dmem_req.
- Byte store: sb to 0x2003, data=0xAB, ready on first REQ cycle → addr=0x2000, mask=1000, wdata=0xAB000000, wen=1; o_valid 2 cycles after accept.
- lh at 0x1002, rdata=0x8001xxxx, valid 3 cycles after request accept → mask=1100, o_load_data=0xFFFF8001; lhu gives 0x00008001.
- Backpressure: i_dmem_ready low 4 cycles → req, addr and mask stable; o_ready=0 throughout; completes after ready.
- lw at 0x1001 with MEM_MISALIGN_TRAP_EN → o_trap=1, o_reg_write=0, no request; without macro → addr=0x1000, mask=1111.
- Assert i_rst in RESP → state IDLE, o_ready=1, o_valid=0; late i_dmem_valid is ignored.
